z_frame_deserializer: RTL



---
 rtl/z_pkg.sv | 15 +
 rtl/z_out_slot.sv | 38 +++
 rtl/z_frame_deserializer.sv | 138 +++++++++++++
 3 files changed

// File: rtl/z_pkg.sv
// Shared types and line levels for the Z-stream frame deserializer.
package z_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_STOP   = 2'd2,
        S_PARITY = 2'd3
    } z_state_t;

    localparam logic Z_IDLE_LVL  = 1'b0;
    localparam logic Z_START_LVL = 1'b1;
    localparam logic Z_STOP_LVL  = 1'b0;

endpackage

// File: rtl/z_out_slot.sv
// Single-entry DATA/DVALID holding register with load/drain/overrun decision
// and a wrapping count of delivered frames.
module z_out_slot #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             dready,
    output logic [WIDTH-1:0] data,
    output logic             dvalid,
    output logic [CNT_W-1:0] frames,
    output logic             overrun
);

    logic accept;

    // A slot being drained on this edge can take a new word at the same time.
    assign accept  = load && (!dvalid || dready);
    assign overrun = load && !accept;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data   <= '0;
            dvalid <= 1'b0;
            frames <= '0;
        end else if (accept) begin
            data   <= din;
            dvalid <= 1'b1;
            frames <= frames + 1'b1;
        end else if (dvalid && dready) begin
            dvalid <= 1'b0;
        end
    end

endmodule

// File: rtl/z_frame_deserializer.sv
// Deframes the serial Z stream (start, WIDTH data bits MSB first, stop) into words.
// Build with Z_DESER_PARITY_CHECK_EN to add an even-parity bit before the stop bit and the PERR flag.
module z_frame_deserializer
    import z_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 5
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Z,
    input  logic             Z_VALID,
    output logic [WIDTH-1:0] DATA,
    output logic             DVALID,
    input  logic             DREADY,
    output logic             FERR,
    output logic             OVR,
    input  logic             CLR_ERR,
`ifdef Z_DESER_PARITY_CHECK_EN
    output logic             PERR,
`endif
    output logic [CNT_W-1:0] FRAMES
);

    z_state_t         state_reg, state_next;
    logic [WIDTH-1:0] shift_reg, shift_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             par_bad_reg, par_bad_next;
    logic             load;
    logic             ferr_set;
    logic             perr_set;
    logic             ovr_set;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg   <= S_IDLE;
            shift_reg   <= '0;
            cnt_reg     <= '0;
            par_bad_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            shift_reg   <= shift_next;
            cnt_reg     <= cnt_next;
            par_bad_reg <= par_bad_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        shift_next   = shift_reg;
        cnt_next     = cnt_reg;
        par_bad_next = par_bad_reg;
        load         = 1'b0;
        ferr_set     = 1'b0;
        perr_set     = 1'b0;
        if (Z_VALID) begin
            case (state_reg)
                S_IDLE: begin
                    if (Z == Z_START_LVL) begin
                        state_next   = S_DATA;
                        cnt_next     = '0;
                        par_bad_next = 1'b0;
                    end
                end
                S_DATA: begin
                    shift_next = {shift_reg[WIDTH-2:0], Z};
                    cnt_next   = cnt_reg + 1'b1;
                    if (cnt_reg == CNT_W'(WIDTH - 1)) begin
`ifdef Z_DESER_PARITY_CHECK_EN
                        state_next = S_PARITY;
`else
                        state_next = S_STOP;
`endif
                    end
                end
`ifdef Z_DESER_PARITY_CHECK_EN
                S_PARITY: begin
                    if ((^shift_reg) != Z) begin
                        perr_set     = 1'b1;
                        par_bad_next = 1'b1;
                    end
                    state_next = S_STOP;
                end
`endif
                S_STOP: begin
                    if (Z == Z_STOP_LVL) begin
                        load       = !par_bad_reg;
                        state_next = S_IDLE;
                    end else begin
                        // A high stop bit is taken as the start bit of the next frame.
                        ferr_set     = 1'b1;
                        state_next   = S_DATA;
                        cnt_next     = '0;
                        par_bad_next = 1'b0;
                    end
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    z_out_slot #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W)
    ) u_slot (
        .clk    (CLK),
        .rst    (RST),
        .load   (load),
        .din    (shift_reg),
        .dready (DREADY),
        .data   (DATA),
        .dvalid (DVALID),
        .frames (FRAMES),
        .overrun(ovr_set)
    );

    // Sticky flags: a new error event beats a simultaneous clear.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            FERR <= 1'b0;
            OVR  <= 1'b0;
        end else begin
            FERR <= ferr_set | (FERR & ~CLR_ERR);
            OVR  <= ovr_set | (OVR & ~CLR_ERR);
        end
    end

`ifdef Z_DESER_PARITY_CHECK_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            PERR <= 1'b0;
        end else begin
            PERR <= perr_set | (PERR & ~CLR_ERR);
        end
    end
`endif

endmodule
